// File: rtl/inst_loader_if.sv
// Loader handshake bundle: control, byte-stream receive side and instruction-memory write port.
interface inst_loader_if #(
   parameter int IW = 16,
   parameter int DW = 9
);
   logic          Start;
   logic [7:0]    RxData;
   logic          RxValid;
   logic          RxReady;
   logic          WrEn;
   logic [IW-1:0] WrAddr;
   logic [DW-1:0] WrData;
   logic          Busy;
   logic          Done;
   logic          Error;

   modport master (
      output Start, RxData, RxValid,
      input  RxReady, WrEn, WrAddr, WrData, Busy, Done, Error
   );

   modport slave (
      input  Start, RxData, RxValid,
      output RxReady, WrEn, WrAddr, WrData, Busy, Done, Error
   );
endinterface

// File: rtl/inst_loader.sv
// Byte-stream program loader: length header + 2-byte instructions written to consecutive addresses.
// Optional trailing XOR checksum enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
   parameter int IW = 16,
   parameter int DW = 9
) (
   input logic          CLK,
   input logic          Reset,
   inst_loader_if.slave bus
);

`ifdef INST_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE, HDR_LO, HDR_HI, INS_LO, INS_HI, WRITE, CHK, DONE
   } state_t;
   localparam state_t LAST = CHK;
`else
   typedef enum logic [2:0] {
      IDLE, HDR_LO, HDR_HI, INS_LO, INS_HI, WRITE, DONE
   } state_t;
   localparam state_t LAST = DONE;
`endif

   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [IW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          rx_ready;
   logic          accept;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
   logic          err_q, err_d;
`endif

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
`ifdef INST_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rx_ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                 (state_q == INS_LO) || (state_q == INS_HI)
`ifdef INST_LOADER_CHECKSUM_EN
                 || (state_q == CHK)
`endif
                 ;
      accept   = rx_ready && bus.RxValid;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d   = accept ? (csum_q ^ bus.RxData) : csum_q;
      err_d    = err_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (bus.Start) begin
               state_d = HDR_LO;
               addr_d  = '0;
`ifdef INST_LOADER_CHECKSUM_EN
               csum_d  = '0;
               err_d   = 1'b0;
`endif
            end
         end
         HDR_LO: if (accept) begin
            cnt_d[7:0] = bus.RxData;
            state_d    = HDR_HI;
         end
         HDR_HI: if (accept) begin
            cnt_d[15:8] = bus.RxData;
            state_d     = ({bus.RxData, cnt_q[7:0]} != 16'd0) ? INS_LO : LAST;
         end
         INS_LO: if (accept) begin
            data_d[7:0] = bus.RxData;
            state_d     = INS_HI;
         end
         INS_HI: if (accept) begin
            data_d[8] = bus.RxData[0];
            state_d   = WRITE;
         end
         // Address/count advance after the strobe cycle, so WrAddr is stable while WrEn=1.
         WRITE: begin
            cnt_d   = cnt_q - 16'd1;
            addr_d  = addr_q + 1'b1;
            state_d = (cnt_q != 16'd1) ? INS_LO : LAST;
         end
`ifdef INST_LOADER_CHECKSUM_EN
         CHK: if (accept) begin
            err_d   = (bus.RxData != csum_q);
            state_d = DONE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign bus.RxReady = rx_ready;
   assign bus.WrEn    = (state_q == WRITE);
   assign bus.WrAddr  = addr_q;
   assign bus.WrData  = data_q;
   assign bus.Busy    = (state_q != IDLE) && (state_q != DONE);
   assign bus.Done    = (state_q == DONE);
`ifdef INST_LOADER_CHECKSUM_EN
   assign bus.Error   = err_q;
`else
   assign bus.Error   = 1'b0;
`endif

endmodule
